bank_register_mp: RTL

- Parametrised multi-port register file for the Decode stage: N_READ registered read ports and N_WRITE write ports.
- Write-to-read bypass, hardwired zero register, and a per-register pending-write scoreboard that flags RAW hazards to the hazard unit.
- A combinational debug read port serves the debug unit.

---
 rtl/bank_register_mp_pkg.sv | 16 +
 rtl/bank_register_scoreboard.sv | 60 ++++++
 rtl/bank_register_mp.sv | 105 ++++++++++
 3 files changed

// File: rtl/bank_register_mp_pkg.sv
// Shared defaults and flattened-bus slicing helpers for the multi-port bank register file.
`ifndef BANK_REGISTER_MP_PKG_SV
`define BANK_REGISTER_MP_PKG_SV

// Port p of a flattened bus of w-bit fields lives at [p*w +: w].
`define BR_LO(idx, w) ((idx) * (w))
`define BR_SLICE(idx, w) `BR_LO(idx, w) +: (w)

package bank_register_mp_pkg;
  localparam int DEF_NB_REG     = 5;
  localparam int DEF_NB_DATA    = 32;
  localparam int DEF_N_REGISTER = 32;
  localparam int ZERO_ADDR      = 0;
endpackage

`endif

// File: rtl/bank_register_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback,
// wiped by flush, plus next-state busy lookup for every read port.
module bank_register_scoreboard
  import bank_register_mp_pkg::*;
#(
  parameter int NB_REG     = DEF_NB_REG,
  parameter int N_REGISTER = DEF_N_REGISTER,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [N_WRITE-1:0]        wr_en,
  input  logic [N_WRITE*NB_REG-1:0] wr_addr,
  input  logic                      sb_set,
  input  logic [NB_REG-1:0]         sb_addr,
  input  logic                      flush,
  input  logic [N_READ*NB_REG-1:0]  rd_addr,
  output logic [N_READ-1:0]         busy_next
);
  logic [N_REGISTER-1:0] sb;
  logic [N_REGISTER-1:0] sb_next;
  logic [NB_REG-1:0]     wa [N_WRITE];
  logic [NB_REG-1:0]     ra [N_READ];

  function automatic logic in_range(input logic [NB_REG-1:0] a);
    return 32'(a) < N_REGISTER;
  endfunction

  for (genvar w = 0; w < N_WRITE; w++) begin : g_wa
    assign wa[w] = wr_addr[`BR_SLICE(w, NB_REG)];
  end
  for (genvar p = 0; p < N_READ; p++) begin : g_ra
    assign ra[p] = rd_addr[`BR_SLICE(p, NB_REG)];
  end

  // Priority: flush > set > writeback clear.
  always_comb begin
    sb_next = sb;
    for (int w = 0; w < N_WRITE; w++) begin
      if (wr_en[w] && in_range(wa[w])) sb_next[wa[w]] = 1'b0;
    end
    if (sb_set && in_range(sb_addr)) sb_next[sb_addr] = 1'b1;
    if (flush) sb_next = '0;
    if (ZERO_REG != 0) sb_next[ZERO_ADDR] = 1'b0;
  end

  always_comb begin
    busy_next = '0;
    for (int p = 0; p < N_READ; p++) begin
      busy_next[p] = in_range(ra[p]) ? sb_next[ra[p]] : 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) sb <= '0;
    else         sb <= sb_next;
  end
endmodule

// File: rtl/bank_register_mp.sv
// Decode-stage multi-port register file with write-to-read bypass, hardwired zero
// register, RAW-hazard busy flags and a combinational debug read port.
module bank_register_mp
  import bank_register_mp_pkg::*;
#(
  parameter int NB_REG     = DEF_NB_REG,
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int N_REGISTER = DEF_N_REGISTER,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [N_READ-1:0]          i_rd_en,
  input  logic [N_READ*NB_REG-1:0]   i_rd_addr,
  output logic [N_READ*NB_DATA-1:0]  o_rd_data,
  output logic [N_READ-1:0]          o_rd_busy,
  input  logic [N_WRITE-1:0]         i_wr_en,
  input  logic [N_WRITE*NB_REG-1:0]  i_wr_addr,
  input  logic [N_WRITE*NB_DATA-1:0] i_wr_data,
  input  logic                       i_sb_set,
  input  logic [NB_REG-1:0]          i_sb_addr,
  input  logic                       i_flush,
  input  logic [NB_REG-1:0]          i_dbg_addr,
  output logic [NB_DATA-1:0]         o_dbg_data
);
  logic [NB_DATA-1:0] regs [N_REGISTER];
  logic [NB_REG-1:0]  wa [N_WRITE];
  logic [NB_DATA-1:0] wd [N_WRITE];
  logic [N_WRITE-1:0] wr_ok;
  logic [NB_REG-1:0]  ra [N_READ];
  logic [NB_DATA-1:0] rd_data_p0 [N_READ];
  logic [N_READ-1:0]  rd_busy_p0;

  function automatic logic in_range(input logic [NB_REG-1:0] a);
    return 32'(a) < N_REGISTER;
  endfunction

  function automatic logic is_zero(input logic [NB_REG-1:0] a);
    return (ZERO_REG != 0) && (a == NB_REG'(ZERO_ADDR));
  endfunction

  for (genvar w = 0; w < N_WRITE; w++) begin : g_wr
    assign wa[w]    = i_wr_addr[`BR_SLICE(w, NB_REG)];
    assign wd[w]    = i_wr_data[`BR_SLICE(w, NB_DATA)];
    assign wr_ok[w] = i_wr_en[w] && in_range(wa[w]) && !is_zero(wa[w]);
  end
  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    assign ra[p] = i_rd_addr[`BR_SLICE(p, NB_REG)];
  end

  bank_register_scoreboard #(
    .NB_REG     (NB_REG),
    .N_REGISTER (N_REGISTER),
    .N_READ     (N_READ),
    .N_WRITE    (N_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .wr_en     (i_wr_en),
    .wr_addr   (i_wr_addr),
    .sb_set    (i_sb_set),
    .sb_addr   (i_sb_addr),
    .flush     (i_flush),
    .rd_addr   (i_rd_addr),
    .busy_next (rd_busy_p0)
  );

  // Stage p0: array lookup with bypass; later write ports override earlier ones.
  always_comb begin
    for (int p = 0; p < N_READ; p++) begin
      rd_data_p0[p] = in_range(ra[p]) ? regs[ra[p]] : '0;
      for (int w = 0; w < N_WRITE; w++) begin
        if (wr_ok[w] && (wa[w] == ra[p])) rd_data_p0[p] = wd[w];
      end
      if (is_zero(ra[p])) rd_data_p0[p] = '0;
    end
  end

  always_comb begin
    o_dbg_data = '0;
    if (in_range(i_dbg_addr) && !is_zero(i_dbg_addr)) o_dbg_data = regs[i_dbg_addr];
  end

  // Stage p0 -> registered outputs and array update.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGISTER; i++) regs[i] <= '0;
      o_rd_data <= '0;
      o_rd_busy <= '0;
    end else begin
      for (int w = 0; w < N_WRITE; w++) begin
        if (wr_ok[w]) regs[wa[w]] <= wd[w];
      end
      for (int p = 0; p < N_READ; p++) begin
        if (i_rd_en[p]) begin
          o_rd_data[`BR_SLICE(p, NB_DATA)] <= rd_data_p0[p];
          o_rd_busy[p]                     <= rd_busy_p0[p];
        end
      end
    end
  end
endmodule
